// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states and
// the default data-memory window.
package load_store_unit_pkg;

  localparam int          DATA_W           = 32;
  localparam logic [31:0] DMEM_BASE_DEF    = 32'h1000_0000;
  localparam int          DMEM_WORDS_DEF   = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane handling: pull a byte/halfword lane out of a memory word
// with sign/zero extension, and merge store data into one lane of a word.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        offset,
  input  size_e             size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged_data
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    lane_b = $signed(rdata[{offset, 3'b000} +: 8]);
    lane_h = $signed(rdata[{offset[1], 4'b0000} +: 16]);
  end

  always_comb begin
    load_data = rdata;
    case (size)
      SIZE_B:  load_data = is_signed ? DATA_W'(lane_b) : DATA_W'($unsigned(lane_b));
      SIZE_H:  load_data = is_signed ? DATA_W'(lane_h) : DATA_W'($unsigned(lane_h));
      default: load_data = rdata;
    endcase
  end

  // Untouched lanes keep the word just read from memory.
  always_comb begin
    merged_data = rdata;
    case (size)
      SIZE_B:  merged_data[{offset, 3'b000} +: 8]    = wdata[7:0];
      SIZE_H:  merged_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-wide data memory with
// registered reads and falling-edge writes; sub-word stores are read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter int          DMEM_WORDS = DMEM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr_rd,
  output logic [31:0]       mem_addr_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [31:0] DMEM_SPAN = 32'(4 * DMEM_WORDS);

  state_e            state, state_nx;
  logic              we_p0;
  size_e             size_p0;
  logic              sgn_p0;
  logic [31:0]       addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              accept;
  logic              req_err;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] store_merged;

  // Offset arithmetic wraps, so the lower bound is checked separately.
  function automatic logic access_err(input logic [31:0] addr, input size_e size);
    logic [31:0] off;
    logic        bad;
    off = addr - DMEM_BASE;
    bad = (addr < DMEM_BASE) || (off >= DMEM_SPAN);
    case (size)
      SIZE_H:  bad = bad | addr[0];
      SIZE_W:  bad = bad | (|addr[1:0]);
      SIZE_X:  bad = 1'b1;
      default: bad = bad;
    endcase
    return bad;
  endfunction

  assign accept  = req_valid && (state == IDLE);
  assign req_err = access_err(req_addr, size_e'(req_size));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                                      state_nx = RESP;
          else if (req_we && (size_e'(req_size) == SIZE_W)) state_nx = WR;
          else                                              state_nx = RD;
        end
      end
      RD:      state_nx = RD_DATA;
      RD_DATA: state_nx = we_p0 ? WR : RESP;
      WR:      state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign mem_read    = (state == RD);
  assign mem_write   = (state == WR);
  assign mem_addr_rd = {addr_p0[31:2], 2'b00};
  assign mem_addr_wr = {addr_p0[31:2], 2'b00};
  assign mem_wdata   = wdata_p0;

  // ---- p0: request latch; RD_DATA folds the lane result back in ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_p0      <= 1'b0;
      size_p0    <= SIZE_B;
      sgn_p0     <= 1'b0;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      we_p0      <= req_we;
      size_p0    <= size_e'(req_size);
      sgn_p0     <= req_signed;
      addr_p0    <= req_addr;
      wdata_p0   <= req_wdata;
      resp_rdata <= '0;
      resp_err   <= req_err;
    end else if (state == RD_DATA) begin
      if (we_p0) wdata_p0   <= store_merged;
      else       resp_rdata <= load_ext;
    end
  end

  lsu_lane_align u_lane_align (
    .rdata       (mem_rdata),
    .wdata       (wdata_p0),
    .offset      (addr_p0[1:0]),
    .size        (size_p0),
    .is_signed   (sgn_p0),
    .load_data   (load_ext),
    .merged_data (store_merged)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: behavioural memory, scoreboard of
// expected responses (error, data, latency) checked as each response appears.
module tb_load_store_unit;

  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr_rd;
  logic [31:0] mem_addr_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:31] = '{default: 32'h0};
  logic [31:0] rd_off, wr_off;
  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wr_addr = '0;
  bit          b2b_mode = 1'b0;
  int          b2b_accepts = 0;
  int          last_resp_cyc = 0;

  load_store_unit #(.DMEM_BASE(BASE), .DMEM_WORDS(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr_rd (mem_addr_rd),
    .mem_addr_wr (mem_addr_wr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  assign rd_off = mem_addr_rd - BASE;
  assign wr_off = mem_addr_wr - BASE;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read) mem_rdata <= mem[rd_off[6:2]];
  end

  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      last_wr_addr = mem_addr_wr;
      mem[wr_off[6:2]] = mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Scoreboard monitor: acceptance happens on the posedge following a
  // negedge that sees req_valid && req_ready.
  always @(negedge clk) begin
    if (req_valid && req_ready) begin
      if (b2b_mode && b2b_accepts > 0) chk("b2b_accept_slot", cyc, last_resp_cyc + 1);
      if (b2b_mode) b2b_accepts++;
      acc_cyc = cyc + 1;
    end
    if (resp_valid) begin
      last_resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
        chk({e.tag, "_rdata"}, resp_rdata, e.rdata);
        chk({e.tag, "_lat"}, cyc - acc_cyc + 1, e.lat);
      end
    end
  end

  task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic run(input string tag, input logic we, input logic [1:0] size,
                     input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic eerr, input logic [31:0] erdata, input int elat);
    exp_q.push_back('{tag, eerr, erdata, elat});
    @(posedge clk); #1;
    drive(we, size, sgn, addr, wdata);
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain(tag);
  endtask

  initial begin
    int rd0, wr0;
    exp_t e;
    // Reset state
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Word store then word load
    wr0 = wr_cnt;
    run("sw_04", 1'b1, 2'b10, 1'b0, BASE + 32'h4, 32'hDEAD_BEEF, 1'b0, 32'h0, 2);
    chk("sw_04_wr_pulses", wr_cnt - wr0, 1);
    chk("sw_04_wr_addr", last_wr_addr, BASE + 32'h4);
    run("lw_04", 1'b0, 2'b10, 1'b0, BASE + 32'h4, 32'h0, 1'b0, 32'hDEAD_BEEF, 3);

    // Sub-word store and sub-word loads
    run("sb_06", 1'b1, 2'b00, 1'b0, BASE + 32'h6, 32'h0000_00A5, 1'b0, 32'h0, 4);
    chk("sb_06_word", mem[1], 32'hDEA5_BEEF);
    run("lb_06", 1'b0, 2'b00, 1'b1, BASE + 32'h6, 32'h0, 1'b0, 32'hFFFF_FFA5, 3);
    run("lbu_06", 1'b0, 2'b00, 1'b0, BASE + 32'h6, 32'h0, 1'b0, 32'h0000_00A5, 3);
    run("lhu_06", 1'b0, 2'b01, 1'b0, BASE + 32'h6, 32'h0, 1'b0, 32'h0000_DEA5, 3);
    run("lh_06", 1'b0, 2'b01, 1'b1, BASE + 32'h6, 32'h0, 1'b0, 32'hFFFF_DEA5, 3);
    run("lbu_04", 1'b0, 2'b00, 1'b0, BASE + 32'h4, 32'h0, 1'b0, 32'h0000_00EF, 3);

    // Error cases: no strobes, 1-cycle response
    rd0 = rd_cnt; wr0 = wr_cnt;
    run("lh_03", 1'b0, 2'b01, 1'b1, BASE + 32'h3, 32'h0, 1'b1, 32'h0, 1);
    run("lw_80", 1'b0, 2'b10, 1'b0, BASE + 32'h80, 32'h0, 1'b1, 32'h0, 1);
    run("sz_11", 1'b1, 2'b11, 1'b0, BASE + 32'h8, 32'h1234_5678, 1'b1, 32'h0, 1);
    run("sw_lo", 1'b1, 2'b10, 1'b0, BASE - 32'h4, 32'h1234_5678, 1'b1, 32'h0, 1);
    chk("err_no_reads", rd_cnt - rd0, 0);
    chk("err_no_writes", wr_cnt - wr0, 0);
    chk("err_sticky", {31'd0, resp_err}, 32'd1);

    // Reset during the WR cycle of a halfword store
    run("sw_08", 1'b1, 2'b10, 1'b0, BASE + 32'h8, 32'h1122_3344, 1'b0, 32'h0, 2);
    wr0 = wr_cnt;
    @(posedge clk); #1;
    drive(1'b1, 2'b01, 1'b0, BASE + 32'h8, 32'h0000_BEEF);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !mem_write; i++) begin
      @(posedge clk); #1;
    end
    chk("sh_reached_wr", {31'd0, mem_write}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_wr_drop", {31'd0, mem_write}, 32'd0);
    chk("rst_wr_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_no_write", wr_cnt - wr0, 0);
    chk("rst_word_kept", mem[2], 32'h1122_3344);

    // Back-to-back loads with req_valid held high
    run("sw_00", 1'b1, 2'b10, 1'b0, BASE, 32'hCAFE_F00D, 1'b0, 32'h0, 2);
    exp_q.push_back('{"b2b_0", 1'b0, 32'hDEA5_BEEF, 3});
    exp_q.push_back('{"b2b_1", 1'b0, 32'h1122_3344, 3});
    exp_q.push_back('{"b2b_2", 1'b0, 32'hFFFF_FFCA, 3});
    b2b_mode = 1'b1;
    b2b_accepts = 0;
    @(posedge clk); #1;
    drive(1'b0, 2'b10, 1'b0, BASE + 32'h4, 32'h0);
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (req_ready) break;
      end
      @(posedge clk); #1;
      if (k == 0) drive(1'b0, 2'b10, 1'b0, BASE + 32'h8, 32'h0);
      else if (k == 1) drive(1'b0, 2'b00, 1'b1, BASE + 32'h3, 32'h0);
      else req_valid = 1'b0;
    end
    wait_drain("b2b");
    chk("b2b_accepts", b2b_accepts, 3);
    b2b_mode = 1'b0;
    e = '{"tail_lw", 1'b0, 32'hCAFE_F00D, 3};
    run(e.tag, 1'b0, 2'b10, 1'b0, BASE, 32'h0, e.err, e.rdata, e.lat);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
